instruction_fetch: RTL

Instruction-fetch stage that initiates reads to the combinational instruction memory and delivers fetched words into the IF/ID pipeline register. It owns the program counter, which is word-indexed (one address per instruction, incremented by 1). It accepts stall and branch-redirect requests from later stages and stops fetching at the end of the loaded program. It sits between the instruction memory and the decode stage.

---
 rtl/instruction_fetch.sv | 84 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the word-indexed PC, reads instruction memory and fills the IF/ID register
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned PROG_LEN   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_adrs,
    input  logic [31:0]           imem_inst,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [31:0]           if_inst,
    output logic                  if_valid,
    output logic                  done,
    output logic [15:0]           fetch_count
);
    localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PROG_END = ADDR_WIDTH'(PROG_LEN);

    typedef enum logic {RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]           if_inst_q, if_inst_d;
    logic                  if_valid_q, if_valid_d;
    logic [15:0]           fetch_count_q, fetch_count_d;

    assign pc_inc      = pc_q + 1'b1;
    assign imem_adrs   = pc_q;
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;
    assign if_valid    = if_valid_q;
    assign done        = (state_q == DONE);
    assign fetch_count = fetch_count_q;

    // Next state: branch beats stall, stall freezes everything, RUN captures one word per cycle
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        if (branch_taken) begin
            pc_d       = branch_target;
            if_valid_d = 1'b0;
            state_d    = (branch_target < PROG_END) ? RUN : DONE;
        end else if (!stall) begin
            if (state_q == RUN) begin
                if_inst_d     = imem_inst;
                if_pc_d       = pc_q;
                if_valid_d    = 1'b1;
                fetch_count_d = fetch_count_q + 16'd1;
                pc_d          = pc_inc;
                state_d       = (pc_inc == PROG_END) ? DONE : RUN;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear; a PC starting past the program comes up DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= (PC_RST < PROG_END) ? RUN : DONE;
            pc_q          <= PC_RST;
            if_pc_q       <= '0;
            if_inst_q     <= '0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end
endmodule
